// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage operand forwarding unit.
package fwd_pkg;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10,
        FWD_IMM   = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } fwd_slot_t;

    localparam fwd_slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/fwd_match.sv
// One source operand compared against one in-flight producer slot.
module fwd_match
    import fwd_pkg::*;
(
    input  fwd_slot_t  i_slot,
    input  logic [4:0] i_src,
    input  logic       i_uses,
    output logic       o_match
);

    // XZR reads as zero, so a producer "writing" it never forwards
    assign o_match = i_slot.valid && i_slot.regwrite && (i_slot.rd == i_src) &&
                     (i_src != XZR) && i_uses;

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding select generation and load-use stall detection for a 5-stage pipe.
// Optional macro FWD_STALL_CNT_EN adds a saturating stall_count output.
module hazard_forward_unit
    import fwd_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_uses_rn,
    input  logic        id_uses_rm,
    input  logic        id_use_imm,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_is_load,
    input  logic        flush,
    output logic [1:0]  fwd_sel_a,
    output logic [1:0]  fwd_sel_b,
    output logic        stall
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    fwd_slot_t r_ex, r_mem;
    fwd_sel_t  r_sel_a, r_sel_b;
    fwd_slot_t w_id_slot;
    fwd_sel_t  w_sel_a_nxt, w_sel_b_nxt;
    logic      w_ex_rn, w_ex_rm, w_mem_rn, w_mem_rm;
    logic      w_issue;

    fwd_match u_match_ex_rn  (.i_slot(r_ex),  .i_src(id_rn), .i_uses(id_uses_rn), .o_match(w_ex_rn));
    fwd_match u_match_ex_rm  (.i_slot(r_ex),  .i_src(id_rm), .i_uses(id_uses_rm), .o_match(w_ex_rm));
    fwd_match u_match_mem_rn (.i_slot(r_mem), .i_src(id_rn), .i_uses(id_uses_rn), .o_match(w_mem_rn));
    fwd_match u_match_mem_rm (.i_slot(r_mem), .i_src(id_rm), .i_uses(id_uses_rm), .o_match(w_mem_rm));

    // Load result is not available until MEM/WB, so a dependent in ID waits one cycle
    assign stall = id_valid && r_ex.valid && r_ex.is_load && r_ex.regwrite &&
                   (w_ex_rn || w_ex_rm) && !flush;

    assign w_issue   = id_valid && !stall && !flush;
    assign w_id_slot = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, is_load: id_is_load};

    always_comb begin
        w_sel_a_nxt = FWD_RF;
        w_sel_b_nxt = FWD_RF;
        if (w_issue) begin
            if (w_ex_rn)       w_sel_a_nxt = FWD_EXMEM;
            else if (w_mem_rn) w_sel_a_nxt = FWD_MEMWB;
            if (id_use_imm)    w_sel_b_nxt = FWD_IMM;
            else if (w_ex_rm)  w_sel_b_nxt = FWD_EXMEM;
            else if (w_mem_rm) w_sel_b_nxt = FWD_MEMWB;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex    <= SLOT_BUBBLE;
            r_mem   <= SLOT_BUBBLE;
            r_sel_a <= FWD_RF;
            r_sel_b <= FWD_RF;
        end else begin
            r_mem   <= r_ex;
            r_ex    <= w_issue ? w_id_slot : SLOT_BUBBLE;
            r_sel_a <= w_sel_a_nxt;
            r_sel_b <= w_sel_b_nxt;
        end
    end

    assign fwd_sel_a = r_sel_a;
    assign fwd_sel_b = r_sel_b;

`ifdef FWD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stall_cnt <= '0;
        else if (stall && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid, id_uses_rn, id_uses_rm, id_use_imm, id_regwrite, id_is_load, flush;
    logic [4:0] id_rn, id_rm, id_rd;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic       stall;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_use_imm(id_use_imm), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .flush(flush),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall)
`ifdef FWD_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic urn, input logic urm, input logic imm,
                         input logic [4:0] rd, input logic rw, input logic ld);
        id_valid = v; id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm;
        id_use_imm = imm; id_rd = rd; id_regwrite = rw; id_is_load = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        idle(); step(); step(); step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1);
        flush = 1'b0;
        step(); step();
        tests++; if (fwd_sel_a !== 2'b00) begin $display("FAIL reset_sel_a got %b want 00", fwd_sel_a); fails++; end
        tests++; if (fwd_sel_b !== 2'b00) begin $display("FAIL reset_sel_b got %b want 00", fwd_sel_b); fails++; end
        tests++; if (stall !== 1'b0) begin $display("FAIL reset_stall got %b want 0", stall); fails++; end
`ifdef FWD_STALL_CNT_EN
        tests++; if (stall_count !== 32'd0) begin $display("FAIL reset_cnt got %0d want 0", stall_count); fails++; end
`endif
        idle();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_ex_forward();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0);   // ADD X1
        step();
        tests++; if (fwd_sel_a !== 2'b00) begin $display("FAIL exfwd_first_sel_a got %b want 00", fwd_sel_a); fails++; end
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);   // ADD X4 <- X1,X2
        #1;
        tests++; if (stall !== 1'b0) begin $display("FAIL exfwd_stall got %b want 0", stall); fails++; end
        step();
        tests++; if (fwd_sel_a !== 2'b01) begin $display("FAIL exfwd_sel_a got %b want 01", fwd_sel_a); fails++; end
        tests++; if (fwd_sel_b !== 2'b00) begin $display("FAIL exfwd_sel_b got %b want 00", fwd_sel_b); fails++; end
        drain();
    endtask

    task automatic test_mem_forward();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);   // producer X3
        step();
        drive(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0); // unrelated
        step();
        drive(1'b1, 5'd12, 5'd3, 1'b1, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0); // consumer X3 in rm
        #1;
        tests++; if (stall !== 1'b0) begin $display("FAIL memfwd_stall got %b want 0", stall); fails++; end
        step();
        tests++; if (fwd_sel_b !== 2'b10) begin $display("FAIL memfwd_sel_b got %b want 10", fwd_sel_b); fails++; end
        tests++; if (fwd_sel_a !== 2'b00) begin $display("FAIL memfwd_sel_a got %b want 00", fwd_sel_a); fails++; end
        drain();
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);   // LDUR X5
        #1;
        tests++; if (stall !== 1'b0) begin $display("FAIL ldu_pre_stall got %b want 0", stall); fails++; end
        step();
        drive(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);   // ADD X8 <- X5,X7
        #1;
        tests++; if (stall !== 1'b1) begin $display("FAIL ldu_stall got %b want 1", stall); fails++; end
`ifdef FWD_STALL_CNT_EN
        tests++; if (stall_count !== 32'd0) begin $display("FAIL ldu_cnt0 got %0d want 0", stall_count); fails++; end
`endif
        step();
        tests++; if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin $display("FAIL ldu_bubble got %b/%b want 00/00", fwd_sel_a, fwd_sel_b); fails++; end
        tests++; if (stall !== 1'b0) begin $display("FAIL ldu_one_cycle got %b want 0", stall); fails++; end
`ifdef FWD_STALL_CNT_EN
        tests++; if (stall_count !== 32'd1) begin $display("FAIL ldu_cnt1 got %0d want 1", stall_count); fails++; end
`endif
        step();
        tests++; if (fwd_sel_a !== 2'b10) begin $display("FAIL ldu_sel_a got %b want 10", fwd_sel_a); fails++; end
        tests++; if (fwd_sel_b !== 2'b00) begin $display("FAIL ldu_sel_b got %b want 00", fwd_sel_b); fails++; end
        drain();
    endtask

    task automatic test_xzr_imm();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0);  // producer X31
        step();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);   // producer X7
        step();
        drive(1'b1, 5'd31, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);  // X31, X7 with imm
        step();
        tests++; if (fwd_sel_a !== 2'b00) begin $display("FAIL xzr_sel_a got %b want 00", fwd_sel_a); fails++; end
        tests++; if (fwd_sel_b !== 2'b11) begin $display("FAIL imm_sel_b got %b want 11", fwd_sel_b); fails++; end
        drive(1'b1, 5'd31, 5'd7, 1'b1, 1'b1, 1'b0, 5'd20, 1'b1, 1'b0); // same, no imm: X7 now in MEM
        step();
        tests++; if (fwd_sel_a !== 2'b00) begin $display("FAIL xzr2_sel_a got %b want 00", fwd_sel_a); fails++; end
        tests++; if (fwd_sel_b !== 2'b10) begin $display("FAIL x7_sel_b got %b want 10", fwd_sel_b); fails++; end
        drain();
    endtask

    task automatic test_no_forward();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd13, 1'b0, 1'b0);  // rd X13, regwrite=0
        step();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1);  // load X12
        step();
        drive(1'b1, 5'd12, 5'd13, 1'b0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0); // rn unused, rm no-writer
        #1;
        tests++; if (stall !== 1'b0) begin $display("FAIL nofwd_stall got %b want 0", stall); fails++; end
        step();
        tests++; if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin $display("FAIL nofwd_sels got %b/%b want 00/00", fwd_sel_a, fwd_sel_b); fails++; end
        drain();
    endtask

    task automatic test_priority();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);   // X4 older
        step();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);   // X4 newer
        step();
        drive(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0);
        step();
        tests++; if (fwd_sel_a !== 2'b01 || fwd_sel_b !== 2'b01) begin $display("FAIL prio_sels got %b/%b want 01/01", fwd_sel_a, fwd_sel_b); fails++; end
        drain();
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);   // LDUR X5
        step();
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0);  // dependent, squashed
        flush = 1'b1;
        #1;
        tests++; if (stall !== 1'b0) begin $display("FAIL flush_stall got %b want 0", stall); fails++; end
        step();
        tests++; if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin $display("FAIL flush_sels got %b/%b want 00/00", fwd_sel_a, fwd_sel_b); fails++; end
        flush = 1'b0;
        drive(1'b1, 5'd14, 5'd0, 1'b1, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0); // reads squashed X14
        step();
        tests++; if (fwd_sel_a !== 2'b00) begin $display("FAIL flush_gone got %b want 00", fwd_sel_a); fails++; end
`ifdef FWD_STALL_CNT_EN
        tests++; if (stall_count !== 32'd1) begin $display("FAIL flush_cnt got %0d want 1", stall_count); fails++; end
`endif
        drain();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);   // LDUR X8
        step();
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);   // LDUR X8 <- [X8]
        #1;
        tests++; if (stall !== 1'b1) begin $display("FAIL b2b_stall1 got %b want 1", stall); fails++; end
        step();
        tests++; if (stall !== 1'b0) begin $display("FAIL b2b_release1 got %b want 0", stall); fails++; end
        step();
        tests++; if (fwd_sel_a !== 2'b10) begin $display("FAIL b2b_sel1 got %b want 10", fwd_sel_a); fails++; end
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);   // ADD X9 <- X8
        #1;
        tests++; if (stall !== 1'b1) begin $display("FAIL b2b_stall2 got %b want 1", stall); fails++; end
        step();
        step();
        tests++; if (fwd_sel_a !== 2'b10) begin $display("FAIL b2b_sel2 got %b want 10", fwd_sel_a); fails++; end
`ifdef FWD_STALL_CNT_EN
        tests++; if (stall_count !== 32'd3) begin $display("FAIL b2b_cnt got %0d want 3", stall_count); fails++; end
`endif
        drain();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);   // producer X2
        step();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1);   // LDUR X6 <- [X2]
        step();
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);  // ADD X10 <- X6
        #1;
        tests++; if (stall !== 1'b1 || fwd_sel_a !== 2'b01) begin $display("FAIL rms_pre got stall=%b sel_a=%b want 1/01", stall, fwd_sel_a); fails++; end
        reset_n = 1'b0;
        #1;
        tests++; if (stall !== 1'b0) begin $display("FAIL rms_stall got %b want 0", stall); fails++; end
        tests++; if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin $display("FAIL rms_sels got %b/%b want 00/00", fwd_sel_a, fwd_sel_b); fails++; end
`ifdef FWD_STALL_CNT_EN
        tests++; if (stall_count !== 32'd0) begin $display("FAIL rms_cnt got %0d want 0", stall_count); fails++; end
`endif
        #2;
        reset_n = 1'b1;
        #1;
        tests++; if (stall !== 1'b0) begin $display("FAIL rms_post_stall got %b want 0", stall); fails++; end
        step();
        tests++; if (fwd_sel_a !== 2'b00) begin $display("FAIL rms_post_sel_a got %b want 00", fwd_sel_a); fails++; end
        drain();
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_xzr_imm();
        test_no_forward();
        test_priority();
        test_flush();
        test_back_to_back();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: id_valid  input  1  ID stage holds a real instruction.
REQ-004 SHALL have ports: id_rn, id_rm  input  5 each  ID source register numbers.
REQ-005 SHALL have ports: id_uses_rn, id_uses_rm  input  1 each  source actually read.
REQ-006 SHALL have ports: id_use_imm  input  1  operand B is the immediate.
REQ-007 SHALL have ports: id_rd, id_regwrite, id_is_load  input  5/1/1  ID destination info.
REQ-008 SHALL have ports: flush  input  1  branch taken; squash the ID instruction.
REQ-009 SHALL have ports: fwd_sel_a, fwd_sel_b  output  2 each  registered select lines for the EX-stage 64-bit 4:1 operand muxes.
REQ-010 SHALL have ports: stall  output  1  combinational; hold PC and IF/ID.
REQ-011 SHALL have port stall_count  output  32  present only under FWD_STALL_CNT_EN.

Function
REQ-012 Select encoding SHALL be: 00 register file; 01 EX/MEM ALU result; 10 MEM/WB result; 11 immediate (sel_b only; sel_a never 11).
REQ-013 SHALL track two in-flight slots, ex_* and mem_*, each holding {valid, rd, regwrite, is_load}.
REQ-014 Each cycle, mem_* SHALL load ex_*; ex_* SHALL load ID info if id_valid && !stall && !flush, else a bubble (valid=0).
REQ-015 A source matches a slot only when: the slot is valid, regwrite=1, rd==source, source!=31 (XZR), and the uses_* bit is 1.
REQ-016 The next sel SHALL be: 01 on an ex_* match; else 10 on a mem_* match; else 00. Newer producer wins.
REQ-017 sel_b SHALL be 11 whenever id_use_imm=1, overriding any forwarding.
REQ-018 fwd_sel_a/b SHALL register on the edge the instruction enters EX, giving 1-cycle latency aligned with ID/EX operands. A bubble entering EX SHALL register 00/00.
REQ-019 stall SHALL be 1 when id_valid && ex_valid && ex_is_load && ex_regwrite && (rn or rm match per REQ-015) && !flush.
REQ-020 Each load-use hazard SHALL produce exactly one stall cycle; after the bubble, the load is in mem_* and REQ-016 selects 10.
REQ-021 If flush and stall are both active in one cycle, flush SHALL win: stall=0 and a bubble enters EX.
REQ-022 Back-to-back loads to the same rd SHALL each stall independently; no state other than ex_*/mem_* SHALL persist.

Reset
REQ-023 While reset_n=0: all slot valid bits=0, fwd_sel_a=fwd_sel_b=00, stall=0, stall_count=0.
REQ-024 Reset asserted mid-stall SHALL clear the stall immediately; the first post-reset instruction SHALL see no forwarding.

Configuration
REQ-025 Macro FWD_STALL_CNT_EN: when defined, stall_count SHALL increment on each cycle with stall=1 and saturate at 32'hFFFFFFFF.
REQ-026 When FWD_STALL_CNT_EN is undefined, the port and the counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package fwd_pkg SHALL hold: the fwd_sel_t enum (FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_IMM), the slot struct typedef, and the constant XZR=5'd31.
REQ-028 One sub-module, fwd_match, SHALL compute the match per REQ-015. It SHALL be instantiated once per source per slot (4 instances).

Verification
REQ-029 Sequence ADD X1 <- ...; then ADD ... <- X1,X2 on the next cycle -> sel_a=01 and sel_b=00 one cycle after the second instruction issues.
REQ-030 Producer of X3, one unrelated instruction, then consumer of X3 in rm -> sel_b=10, with no stall.
REQ-031 LDUR X5; then ADD using X5 -> stall=1 for exactly one cycle, a bubble (sels 00), then sel=10. With FWD_STALL_CNT_EN defined, stall_count goes 0 -> 1.
REQ-032 Producers of X31 and of X7, or a consumer with id_use_imm=1 -> X31 never forwards; sel_b=11 regardless of an X7 match in rm.
REQ-033 Load-use hazard with flush=1 in the same cycle -> stall=0 and sels 00; assert reset_n=0 during a stall -> stall=0 and sels 00 immediately.
